uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
CPU-side receive buffer directly downstream of rx_valid_gen, in the cpu_clk domain. It captures one byte of rx_data on every single-cycle cpu_valid pulse and stores it in a show-ahead FIFO. The FIFO is drained by the CPU through a valid/ready handshake. When a byte arrives while the FIFO is full, the byte is dropped and a sticky overrun flag is set.

Parameters:
DATA_WIDTH, 8, width of each received character
DEPTH, 8, number of FIFO entries; power of two, minimum 2
AFULL_LEVEL, 6, almost-full threshold; only used when UART_RX_FIFO_AFULL_EN is defined

Ports:
cpu_clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
cpu_valid  input  1  one-cycle write strobe from rx_valid_gen
rx_data  input  DATA_WIDTH  received character; sampled when cpu_valid=1
rd_data  output  DATA_WIDTH  head-of-FIFO character; meaningful only while rd_valid=1
rd_valid  output  1  FIFO non-empty
rd_ready  input  1  CPU accepts rd_data; a pop occurs when rd_valid && rd_ready
count  output  $clog2(DEPTH+1)  number of stored entries
full  output  1  count==DEPTH
empty  output  1  count==0
overrun  output  1  sticky flag: a character was dropped
overrun_clr  input  1  one-cycle clear of overrun
almost_full  output  1  present only with UART_RX_FIFO_AFULL_EN

Behaviour:
- Reset (async assert, sync-safe deassert):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, rd_valid=0, overrun=0, almost_full=0
  - rd_data=0 while empty after reset
  - Storage contents are not reset.
- push = cpu_valid && (!full || pop). pop = rd_valid && rd_ready.
- Push:
  - Writes rx_data to mem[wr_ptr].
  - wr_ptr advances by 1 and wraps from DEPTH-1 to 0.
- Pop: rd_ptr advances by 1 and wraps from DEPTH-1 to 0.
- Count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- full, empty and rd_valid are registered, derived from next-state count, and update the same edge as count.
- Show-ahead read:
  - rd_data = mem[rd_ptr], combinational from registered rd_ptr.
  - Write-to-read latency is 1 cycle: a push into an empty FIFO gives rd_valid=1 and rd_data=that byte on the next cycle.
  - No bypass in the same cycle.
- Boundary conditions:
  - Empty with cpu_valid: push accepted. No pop is possible because rd_valid=0.
  - Full with cpu_valid and pop in the same cycle: push accepted, pop performed, count stays DEPTH.
  - Full with cpu_valid and no pop: byte dropped, pointers and count unchanged, overrun=1 next cycle.
  - rd_ready while empty: ignored, no pointer movement.
  - overrun_clr and a new drop in the same cycle: set wins, overrun stays 1.
  - overrun_clr with no drop: overrun=0 next cycle.
  - rst asserted mid-operation: all state returns to reset values immediately. Buffered data is lost.
- Control state (per cycle): IDLE (empty), HOLDING (0<count<DEPTH), FULL.
  - IDLE -> HOLDING on push.
  - HOLDING -> FULL on push without pop at count==DEPTH-1.
  - HOLDING -> IDLE on pop without push at count==1.
  - FULL -> HOLDING on pop without push.
  - Implemented as count comparisons or an explicit FSM; outputs must match the above.

Optional Feature:
UART_RX_FIFO_AFULL_EN
- Defined:
  - almost_full output exists.
  - almost_full is registered: 1 when next-state count >= AFULL_LEVEL, else 0.
  - Reset value 0. Updates the same edge as count.
- Not defined:
  - almost_full port and its logic are absent.
  - AFULL_LEVEL is unused.
  - All other behaviour is identical.

Test Plan:
- Reset then single write: after rst release, one cpu_valid pulse with rx_data=0x5A -> next cycle rd_valid=1, rd_data=0x5A, count=1, empty=0; then pulse rd_ready -> rd_valid=0, empty=1.
- Fill to full: 8 pulses with data 0x01..0x08 -> count=8, full=1. A 9th pulse with 0xFF -> overrun=1. Drain with rd_ready held high -> reads 0x01..0x08 in order, 0xFF never appears.
- Full, simultaneous push and pop: fill with 0x10..0x17, then cpu_valid (0x99) and rd_ready in the same cycle -> count stays 8, overrun=0, last read after drain is 0x99.
- Pointer wrap: 20 write/read pairs of incrementing data 0x00..0x13 with a random 0-3 cycle CPU delay -> every byte read in order, count never exceeds 8.
- Overrun clear: set overrun, then overrun_clr alone -> overrun=0. Set it again and assert overrun_clr in the same cycle as another drop -> overrun stays 1.
- Mid-operation reset: with count=5, assert rst asynchronously between edges -> immediately rd_valid=0, count=0, empty=1, overrun=0. With UART_RX_FIFO_AFULL_EN: 6 writes -> almost_full=1; one read -> almost_full=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// CPU-side UART receive buffer: show-ahead FIFO with a sticky overrun flag for dropped bytes.
// Optional almost_full output is enabled with `define UART_RX_FIFO_AFULL_EN.
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                         cpu_clk,
    input  logic                         rst,
    input  logic                         cpu_valid,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overrun,
    input  logic                         overrun_clr
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    output logic                         almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_param_check
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and AFULL_LEVEL in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_rd_valid;
    logic                  r_overrun;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [CW-1:0]         w_count_nxt;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_pop  = r_rd_valid && rd_ready;
    assign w_push = cpu_valid && (!r_full || w_pop);
    assign w_drop = cpu_valid && r_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Pointers are AW bits wide over a power-of-two depth, so +1 wraps DEPTH-1 to 0.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_rd_valid <= (w_count_nxt != '0);
            if (w_drop)           r_overrun <= 1'b1;
            else if (overrun_clr) r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_AFULL_EN
    logic r_almost_full;

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) r_almost_full <= 1'b0;
        else     r_almost_full <= (w_count_nxt >= CW'(AFULL_LEVEL));
    end

    assign almost_full = r_almost_full;
`endif

    // Head is forced to zero while empty so uninitialised storage never shows on rd_data.
    assign rd_data  = r_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overrun  = r_overrun;

endmodule
